gcd_job_sequencer: RTL and testbench
====================================

Name: gcd_job_sequencer

Overview:
- Upstream feeder for the subtractive GCD controller/datapath pair. Accepts operand pairs over a valid/ready interface and clears the GCD core before each job.
- Presents A then B on the core's shared data input, pulses start, and waits for done with a timeout.
- Returns the result over a valid/ready output interface.
- Handles zero operands locally, because the subtractive core never terminates on them.

Parameters:
- W, 16, operand and result width.
- TIMEOUT, 1000, maximum RUN cycles before abort; must be ≥ 2.
- CNT_W, 16, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- gcd_clr  out  1  one-cycle pulse returning the GCD core to its idle/load-A state.
- gcd_start  out  1  start to GCD core.
- gcd_data_in  out  W  shared operand bus to the core's A/B registers.
- gcd_done  in  1  core done.
- gcd_result  in  W  core result (A register), valid while gcd_done=1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_gcd  out  W  GCD result; 0 on error.
- out_err  out  1  1 = core timed out.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, timeout counter=0, a_reg=b_reg=0.
  - out_gcd=0, out_err=0, out_valid=0, gcd_clr=0, gcd_start=0, gcd_data_in=0.
  - in_ready=0 while rst is high; in_ready = (state==IDLE) && !rst.
  - Reset mid-job abandons the job: no out_valid is issued and the captured pair is dropped.
- States: IDLE, CLR, LOAD_A, LOAD_B, RUN, OUT. All control outputs are decoded from state and are registered-state based (no combinational path from gcd_done to outputs).
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture a_reg=in_a, b_reg=in_b.
  - If in_a==0 or in_b==0: out_gcd=in_a|in_b, out_err=0, go to OUT (bypass; the core is untouched).
  - Otherwise go to CLR.
- CLR: gcd_clr=1 for exactly one cycle -> LOAD_A.
- LOAD_A: gcd_data_in=a_reg, gcd_start=1; the core latches A on this edge -> LOAD_B.
- LOAD_B: gcd_data_in=b_reg, gcd_start=0; the core latches B on this edge; counter cleared to 0 -> RUN.
- RUN:
  - gcd_data_in=0; counter increments each cycle.
  - gcd_done is sampled only in RUN; done in any other state is ignored (the core holds a stale done).
  - If gcd_done=1: out_gcd=gcd_result, out_err=0 -> OUT.
  - Else if counter==TIMEOUT-1: out_gcd=0, out_err=1 -> OUT.
  - If done and timeout occur in the same cycle, done wins.
- OUT:
  - out_valid=1; out_gcd and out_err are held stable until out_ready=1.
  - On out_ready=1 -> IDLE.
  - in_ready=0, so the next pair is accepted no earlier than the cycle after the handshake.
- Latency, nonzero pair (accept at edge 0):
  - CLR during cycle 1, LOAD_A cycle 2, LOAD_B cycle 3, RUN from cycle 4.
  - out_valid rises the cycle after gcd_done is first seen high in RUN.
- Latency, zero bypass: out_valid=1 in the cycle after accept.
- Throughput: one job in flight; no buffering.
- Arithmetic: none beyond compare-to-zero, bitwise OR, and counter increment. Counter does not wrap, because RUN exits at TIMEOUT-1.

Test Plan:
- Reset, then in_a=12, in_b=18, core model returns 6 -> gcd_clr pulse one cycle after accept; gcd_data_in=12 with gcd_start=1, then 18 on the next cycle; out_valid with out_gcd=6, out_err=0.
- in_a=0, in_b=7 -> out_gcd=7 one cycle after accept, no gcd_clr/gcd_start activity; in_a=0, in_b=0 -> out_gcd=0, out_err=0.
- in_a=5, in_b=9 with gcd_done tied 0, TIMEOUT=8 -> out_valid after exactly 8 RUN cycles, out_gcd=0, out_err=1.
- in_a=35, in_b=21 (result 7) with out_ready held low 5 cycles -> out_valid and out_gcd=7 stable for all 5 cycles, in_ready=0, a new in_valid is ignored; after the handshake, IDLE and in_ready=1.
- Stale gcd_done=1 held through CLR/LOAD_A/LOAD_B -> no early completion; result is taken only from RUN.
- rst asserted during RUN of (100,75) -> next cycle IDLE with all outputs 0 and no out_valid; a following job (100,75) returns 25.

Source files
------------

// File: rtl/gcd_job_sequencer_if.sv
// rtl/gcd_job_sequencer_if.sv - job, core and result signal bundle for the GCD job sequencer
interface gcd_job_sequencer_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         gcd_clr;
    logic         gcd_start;
    logic [W-1:0] gcd_data_in;
    logic         gcd_done;
    logic [W-1:0] gcd_result;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_gcd;
    logic         out_err;
    logic         busy;

    // Sequencer side: accepts jobs, drives the core, produces results.
    modport master (
        input  in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
        output in_ready, gcd_clr, gcd_start, gcd_data_in, out_valid, out_gcd, out_err, busy
    );

    // Environment side: job source, GCD core and result consumer.
    modport slave (
        output in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
        input  in_ready, gcd_clr, gcd_start, gcd_data_in, out_valid, out_gcd, out_err, busy
    );
endinterface

// File: rtl/gcd_job_sequencer.sv
// rtl/gcd_job_sequencer.sv - feeds operand pairs to a subtractive GCD core with timeout and zero bypass
module gcd_job_sequencer #(
    parameter int W       = 16,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    gcd_job_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_LOAD_A = 3'd2,
        S_LOAD_B = 3'd3,
        S_RUN    = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   gcd_q, gcd_d;
    logic           err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d = bus.in_a;
                    b_d = bus.in_b;
                    // A zero operand would never terminate in the subtractive core.
                    if ((bus.in_a == '0) || (bus.in_b == '0)) begin
                        gcd_d   = bus.in_a | bus.in_b;
                        err_d   = 1'b0;
                        state_d = S_OUT;
                    end else begin
                        state_d = S_CLR;
                    end
                end
            end
            S_CLR:    state_d = S_LOAD_A;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_ONE;
                if (bus.gcd_done) begin
                    gcd_d   = bus.gcd_result;
                    err_d   = 1'b0;
                    state_d = S_OUT;
                end else if (cnt_q == CNT_LAST) begin
                    gcd_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every output is a decode of registered state; gcd_done never reaches an output directly.
    always_comb begin
        bus.gcd_data_in = '0;
        if (state_q == S_LOAD_A) begin
            bus.gcd_data_in = a_q;
        end else if (state_q == S_LOAD_B) begin
            bus.gcd_data_in = b_q;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.gcd_clr   = (state_q == S_CLR);
    assign bus.gcd_start = (state_q == S_LOAD_A);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_gcd   = gcd_q;
    assign bus.out_err   = err_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_gcd_job_sequencer.sv
// tb/tb_gcd_job_sequencer.sv - directed scoreboard bench for gcd_job_sequencer with a subtractive core model
module tb_gcd_job_sequencer;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gcd_job_sequencer_if #(.W(W)) bus ();

    gcd_job_sequencer #(.W(W), .TIMEOUT(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [W:0] exp_q[$];

    // Subtractive GCD core model: clr -> latch A on start -> latch B -> iterate.
    int         phase;
    logic [W-1:0] ra, rb;
    logic       done_m;
    logic       core_en;
    logic       stale_arm;

    always @(posedge clk) begin
        if (rst) begin
            phase  <= 0;
            done_m <= 1'b0;
            ra     <= '0;
            rb     <= '0;
        end else if (bus.gcd_clr) begin
            phase  <= 1;
            done_m <= 1'b0;
        end else if (phase == 1 && bus.gcd_start) begin
            ra    <= bus.gcd_data_in;
            phase <= 2;
        end else if (phase == 2) begin
            rb    <= bus.gcd_data_in;
            phase <= 3;
        end else if (phase == 3 && core_en) begin
            if (ra == rb) begin
                done_m <= 1'b1;
                phase  <= 4;
            end else if (ra > rb) begin
                ra <= ra - rb;
            end else begin
                rb <= rb - ra;
            end
        end
    end

    assign bus.gcd_done   = done_m | (stale_arm && phase < 3);
    assign bus.gcd_result = (stale_arm && phase < 3) ? 16'hBEEF : ra;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [W:0] e;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(bus.out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_out_gcd", 32'(bus.out_gcd), 32'(e[W-1:0]));
                chk("sb_out_err", 32'(bus.out_err), 32'(e[W]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        chk("in_ready_at_accept", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int limit);
        int n = 0;
        while (!bus.out_valid && n < limit) begin
            step();
            n++;
        end
        chk("wait_out_valid", 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        core_en       = 1'b1;
        stale_arm     = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_gcd_clr", 32'(bus.gcd_clr), 32'd0);
        chk("rst_gcd_start", 32'(bus.gcd_start), 32'd0);
        chk("rst_data_in", 32'(bus.gcd_data_in), 32'd0);
        chk("rst_out_gcd", 32'(bus.out_gcd), 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        step();

        // Nominal job 12,18 -> 6 with load sequencing
        exp_q.push_back({1'b0, 16'd6});
        send(16'd12, 16'd18);
        chk("j1_clr", 32'(bus.gcd_clr), 32'd1);
        chk("j1_in_ready_busy", 32'(bus.in_ready), 32'd0);
        step();
        chk("j1_clr_one_cycle", 32'(bus.gcd_clr), 32'd0);
        chk("j1_start", 32'(bus.gcd_start), 32'd1);
        chk("j1_data_a", 32'(bus.gcd_data_in), 32'd12);
        step();
        chk("j1_start_low", 32'(bus.gcd_start), 32'd0);
        chk("j1_data_b", 32'(bus.gcd_data_in), 32'd18);
        step();
        chk("j1_run_data", 32'(bus.gcd_data_in), 32'd0);
        wait_out(50);
        step();
        chk("j1_back_idle", 32'(bus.in_ready), 32'd1);

        // Zero bypass
        exp_q.push_back({1'b0, 16'd7});
        send(16'd0, 16'd7);
        chk("zb_out_valid", 32'(bus.out_valid), 32'd1);
        chk("zb_no_clr", 32'(bus.gcd_clr), 32'd0);
        chk("zb_no_start", 32'(bus.gcd_start), 32'd0);
        step();
        exp_q.push_back({1'b0, 16'd0});
        send(16'd0, 16'd0);
        chk("zz_out_valid", 32'(bus.out_valid), 32'd1);
        step();

        // Timeout: 8 RUN cycles, core never finishes
        core_en = 1'b0;
        exp_q.push_back({1'b1, 16'd0});
        send(16'd5, 16'd9);
        for (int i = 0; i < 10; i++) step();
        chk("to_not_yet", 32'(bus.out_valid), 32'd0);
        step();
        chk("to_out_valid", 32'(bus.out_valid), 32'd1);
        chk("to_out_err", 32'(bus.out_err), 32'd1);
        step();
        core_en = 1'b1;

        // Backpressure: 35,21 -> 7 held for 5 cycles, stray pair ignored
        exp_q.push_back({1'b0, 16'd7});
        bus.out_ready = 1'b0;
        send(16'd35, 16'd21);
        wait_out(50);
        bus.in_a     = 16'd1;
        bus.in_b     = 16'd1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_gcd", 32'(bus.out_gcd), 32'd7);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_idle_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_idle_busy", 32'(bus.busy), 32'd0);

        // Stale done held through CLR/LOAD phases
        stale_arm = 1'b1;
        exp_q.push_back({1'b0, 16'd12});
        send(16'd48, 16'd36);
        wait_out(50);
        step();
        stale_arm = 1'b0;

        // Reset during RUN abandons the job
        send(16'd100, 16'd75);
        for (int i = 0; i < 4; i++) step();
        chk("mr_busy_run", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_data_in", 32'(bus.gcd_data_in), 32'd0);
        chk("mr_out_gcd", 32'(bus.out_gcd), 32'd0);
        for (int i = 0; i < 10; i++) step();
        chk("mr_no_result", 32'(bus.out_valid), 32'd0);
        exp_q.push_back({1'b0, 16'd25});
        send(16'd100, 16'd75);
        wait_out(50);
        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
